// File: rtl/alu_pkg.sv
// Purpose: shared function codes, scheduler state type and decode helpers for the ALU issue path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int FUNCT_WIDTH = 6;

    typedef logic [FUNCT_WIDTH-1:0] funct_t;

    // Function codes understood by the ALU/Shifter/HiLo datapath.
    localparam funct_t AND  = 6'b100100;
    localparam funct_t OR   = 6'b100101;
    localparam funct_t ADD  = 6'b100000;
    localparam funct_t SUB  = 6'b100010;
    localparam funct_t SLT  = 6'b101010;
    localparam funct_t SRL  = 6'b000010;
    localparam funct_t DIVU = 6'b011011;
    localparam funct_t MFHI = 6'b010000;
    localparam funct_t MFLO = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        WB   = 2'd3
    } sched_state_t;

    // Ops that touch the HiLo pair or the divider; these cannot issue while a
    // divide is in flight, otherwise they would read stale Hi/Lo or clobber it.
    function automatic logic is_hilo_dep(input funct_t f);
        return (f == DIVU) || (f == MFHI) || (f == MFLO);
    endfunction

    function automatic logic is_supported(input funct_t f);
        case (f)
            AND, OR, ADD, SUB, SLT, SRL, DIVU, MFHI, MFLO: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Purpose: op-issue handshake plus mux-select / divider-control bundle between requester and scheduler.
// Latency: n/a (wires only).
// Backpressure: op_valid/op_ready; an op transfers on the edge where both are high.
// Ports: op_valid, funct (requester -> scheduler); op_ready, mux_sel, out_valid, illegal,
//        div_start, div_step, hilo_we, div_busy (scheduler -> requester/datapath).
interface alu_op_scheduler_if #(
    parameter int FUNCT_W = 6
);
    logic               op_valid;
    logic [FUNCT_W-1:0] funct;
    logic               op_ready;
    logic [FUNCT_W-1:0] mux_sel;
    logic               out_valid;
    logic               illegal;
    logic               div_start;
    logic               div_step;
    logic               hilo_we;
    logic               div_busy;

    modport master (
        output op_valid, funct,
        input  op_ready, mux_sel, out_valid, illegal,
               div_start, div_step, hilo_we, div_busy
    );

    modport slave (
        input  op_valid, funct,
        output op_ready, mux_sel, out_valid, illegal,
               div_start, div_step, hilo_we, div_busy
    );
endinterface

// File: rtl/div_cycle_counter.sv
// Purpose: divide step counter; loads DIV_CYCLES-1, counts down, flags zero.
// Latency: new count visible the cycle after load/dec.
// Backpressure: none; dec at zero is ignored so the count never wraps.
// Ports: clk, rst_n, load (preset to DIV_CYCLES-1), dec (count down), zero (count == 0).
module div_cycle_counter #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(DIV_CYCLES - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_scheduler.sv
// Purpose: issue controller for the ALU/Shifter/HiLo datapath; drives mux select and sequences DIVU.
// Latency: single-cycle ops give out_valid/mux_sel one cycle after accept; DIVU occupies DIV_CYCLES+2 cycles.
// Backpressure: op_ready drops only for DIVU/MFHI/MFLO while a divide is in flight; other ops always issue.
// Ports: clk, rst_n (async, active-low), bus (slave side of alu_op_scheduler_if).
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int FUNCT_W    = 6,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_op_scheduler_if.slave     bus
);
    sched_state_t       state_q,     state_d;
    logic [FUNCT_W-1:0] mux_sel_q,   mux_sel_d;
    logic               out_valid_q, out_valid_d;
    logic               illegal_q,   illegal_d;
    logic               div_start_q, div_start_d;
    logic               div_step_q,  div_step_d;
    logic               hilo_we_q,   hilo_we_d;
    logic               div_busy_q,  div_busy_d;

    logic op_ready;
    logic accept;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    // Combinational on funct/state: a HiLo-dependent op waiting in WB is
    // accepted in the following IDLE cycle, so MFHI/MFLO see the new Hi/Lo.
    assign op_ready = !(is_hilo_dep(bus.funct) && (state_q != IDLE));
    assign accept   = bus.op_valid && op_ready;

    div_cycle_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        mux_sel_d   = mux_sel_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        if (accept) begin
            mux_sel_d = bus.funct;
            if (bus.funct == DIVU) begin
                // op_ready guarantees we are in IDLE here. DIVU returns
                // nothing on dataOut; completion is the hilo_we pulse.
                state_d = LOAD;
            end else begin
                out_valid_d = 1'b1;
                illegal_d   = !is_supported(bus.funct);
            end
        end

        case (state_q)
            LOAD: begin
                cnt_load = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (cnt_zero) begin
                    state_d = WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: ;
        endcase

        // Divider controls are registered images of the next state so they
        // line up exactly with the state they describe.
        div_start_d = (state_d == LOAD);
        div_step_d  = (state_d == RUN);
        hilo_we_d   = (state_d == WB);
        div_busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mux_sel_q   <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            div_start_q <= 1'b0;
            div_step_q  <= 1'b0;
            hilo_we_q   <= 1'b0;
            div_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_sel_q   <= mux_sel_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            div_start_q <= div_start_d;
            div_step_q  <= div_step_d;
            hilo_we_q   <= hilo_we_d;
            div_busy_q  <= div_busy_d;
        end
    end

    assign bus.op_ready  = op_ready;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.div_start = div_start_q;
    assign bus.div_step  = div_step_q;
    assign bus.hilo_we   = hilo_we_q;
    assign bus.div_busy  = div_busy_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Purpose: directed self-checking bench for alu_op_scheduler.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_op_scheduler;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.FUNCT_W(6)) bus ();

    alu_op_scheduler #(
        .DIV_CYCLES (32),
        .FUNCT_W    (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input funct_t f);
        bus.op_valid = v;
        bus.funct    = f;
    endtask

    // DIVU on an idle scheduler; observes 40 cycles after the accepting edge.
    task automatic divu_alone(input string pfx);
        int ns, nst, nwe, nbz, we_at, st_first;
        ns = 0; nst = 0; nwe = 0; nbz = 0; we_at = -1; st_first = -1;
        drive(1'b1, DIVU);
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin
                chk({pfx, "_mux_divu"}, int'(bus.mux_sel), int'(DIVU));
                chk({pfx, "_ov_divu"},  int'(bus.out_valid), 0);
                drive(1'b0, ADD);
            end
            ns  += int'(bus.div_start);
            nst += int'(bus.div_step);
            nwe += int'(bus.hilo_we);
            nbz += int'(bus.div_busy);
            if (bus.hilo_we && we_at < 0)     we_at = i;
            if (bus.div_step && st_first < 0) st_first = i;
        end
        chk({pfx, "_start_cnt"}, ns, 1);
        chk({pfx, "_step_cnt"},  nst, 32);
        chk({pfx, "_step_first"}, st_first, 2);
        chk({pfx, "_we_cnt"},    nwe, 1);
        chk({pfx, "_we_at"},     we_at, 34);
        chk({pfx, "_busy_cnt"},  nbz, 34);
    endtask

    initial begin
        funct_t ops4 [4];
        funct_t ops3 [3];
        int ns, nst, nwe, nbz, we_at, nlow, nov, first_ov;

        ops4 = '{ADD, SUB, SRL, MFLO};
        ops3 = '{ADD, OR, SLT};

        // Reset state
        drive(1'b0, 6'b000000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux",   int'(bus.mux_sel), 0);
        chk("rst_ov",    int'(bus.out_valid), 0);
        chk("rst_ill",   int'(bus.illegal), 0);
        chk("rst_start", int'(bus.div_start), 0);
        chk("rst_step",  int'(bus.div_step), 0);
        chk("rst_we",    int'(bus.hilo_we), 0);
        chk("rst_busy",  int'(bus.div_busy), 0);
        drive(1'b0, DIVU);
        #1;
        chk("rst_rdy_divu", int'(bus.op_ready), 1);
        rst_n = 1'b1;
        step();

        // Back-to-back single-cycle ops
        drive(1'b1, ops4[0]);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_ov",  int'(bus.out_valid), 1);
            chk("seq_mux", int'(bus.mux_sel), int'(ops4[i]));
            chk("seq_ill", int'(bus.illegal), 0);
            if (i < 3) drive(1'b1, ops4[i+1]);
            else       drive(1'b0, ADD);
        end
        step();
        chk("idle_ov",   int'(bus.out_valid), 0);
        chk("idle_hold", int'(bus.mux_sel), int'(MFLO));

        // DIVU alone
        divu_alone("div");

        // DIVU with ADD/OR/SLT issued during RUN
        ns = 0; nst = 0; nwe = 0; nbz = 0; we_at = -1;
        drive(1'b1, DIVU);
        for (int i = 1; i <= 40; i++) begin
            step();
            ns  += int'(bus.div_start);
            nst += int'(bus.div_step);
            nwe += int'(bus.hilo_we);
            nbz += int'(bus.div_busy);
            if (bus.hilo_we && we_at < 0) we_at = i;
            if (i >= 11 && i <= 13) begin
                chk("mix_ov",  int'(bus.out_valid), 1);
                chk("mix_mux", int'(bus.mux_sel), int'(ops3[i-11]));
            end
            if (i == 14) chk("mix_ov_end", int'(bus.out_valid), 0);
            if (i >= 10 && i <= 12) begin
                drive(1'b1, ops3[i-10]);
                #1;
                chk("mix_rdy", int'(bus.op_ready), 1);
            end else begin
                drive(1'b0, ADD);
            end
        end
        chk("mix_start_cnt", ns, 1);
        chk("mix_step_cnt",  nst, 32);
        chk("mix_we_cnt",    nwe, 1);
        chk("mix_we_at",     we_at, 34);
        chk("mix_busy_cnt",  nbz, 34);

        // DIVU then MFHI held until IDLE
        nlow = 0; nov = 0; first_ov = -1; we_at = -1;
        drive(1'b1, DIVU);
        for (int i = 1; i <= 40; i++) begin
            step();
            nov += int'(bus.out_valid);
            if (bus.out_valid && first_ov < 0) begin
                first_ov = i;
                chk("mfhi_mux", int'(bus.mux_sel), int'(MFHI));
            end
            if (bus.hilo_we && we_at < 0) we_at = i;
            if (i == 1)  drive(1'b1, MFHI);
            if (i == 36) drive(1'b0, ADD);
            #1;
            if (bus.op_valid && !bus.op_ready) nlow++;
        end
        chk("mfhi_held_cycles", nlow, 34);
        chk("mfhi_we_at",       we_at, 34);
        chk("mfhi_ov_at",       first_ov, 36);
        chk("mfhi_ov_cnt",      nov, 1);

        // Reset in the middle of RUN
        drive(1'b1, DIVU);
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 1) drive(1'b0, ADD);
        end
        chk("pre_rst_step", int'(bus.div_step), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_step",  int'(bus.div_step), 0);
        chk("arst_busy",  int'(bus.div_busy), 0);
        chk("arst_mux",   int'(bus.mux_sel), 0);
        chk("arst_we",    int'(bus.hilo_we), 0);
        chk("arst_start", int'(bus.div_start), 0);
        nwe = 0; nbz = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 2) rst_n = 1'b1;
            nwe += int'(bus.hilo_we);
            nbz += int'(bus.div_busy);
        end
        chk("abort_we_cnt",   nwe, 0);
        chk("abort_busy_cnt", nbz, 0);
        divu_alone("post_rst");

        // Unsupported function code
        drive(1'b1, 6'b111111);
        step();
        chk("ill_ov",  int'(bus.out_valid), 1);
        chk("ill_ill", int'(bus.illegal), 1);
        chk("ill_mux", int'(bus.mux_sel), 63);
        drive(1'b1, ADD);
        step();
        chk("ill_clr_ov",  int'(bus.out_valid), 1);
        chk("ill_clr_ill", int'(bus.illegal), 0);
        chk("ill_clr_mux", int'(bus.mux_sel), int'(ADD));
        drive(1'b0, ADD);
        step();
        chk("ill_end_ov", int'(bus.out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
